// File: rtl/window_3x3_if.sv
// Pixel stream interface for the 3x3 window generator: raster-order pixel input
// on the master side, registered neighbourhood output on the slave side.
interface window_3x3_if #(
  parameter int DATA_W     = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
);
  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);

  logic                  en;
  logic [DATA_W-1:0]     data;
  logic [9*DATA_W-1:0]   window;
  logic                  out_valid;
  logic [COL_W-1:0]      out_col;
  logic [ROW_W-1:0]      out_row;
  logic                  frame_done;

  modport master (
    output en, data,
    input  window, out_valid, out_col, out_row, frame_done
  );

  modport slave (
    input  en, data,
    output window, out_valid, out_col, out_row, frame_done
  );
endinterface

// File: rtl/window_3x3.sv
// Streaming 3x3 neighbourhood generator: two line buffers feed a 3x3 register
// window, and only interior neighbourhoods are flagged valid.
module window_3x3 #(
  parameter int DATA_W     = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic         clk,
  input  logic         reset,
  window_3x3_if.slave  pix
);
  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  typedef enum logic {FILL, RUN} state_t;

  state_t                state_q, state_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [9*DATA_W-1:0]   win_q, win_d;
  logic                  valid_q, valid_d;
  logic [COL_W-1:0]      out_col_q, out_col_d;
  logic [ROW_W-1:0]      out_row_q, out_row_d;
  logic                  frame_done_q, frame_done_d;

  logic [DATA_W-1:0]     lb0_q [IMG_WIDTH];
  logic [DATA_W-1:0]     lb1_q [IMG_WIDTH];

  logic [DATA_W-1:0]     lb0_rd;
  logic [DATA_W-1:0]     lb1_rd;
  logic [3*DATA_W-1:0]   new_col;
  logic                  last_col;
  logic                  last_row;

  // Read happens combinationally on the current column, so the write on the
  // same edge lands after the old contents have been captured into the window.
  assign lb0_rd   = lb0_q[col_q];
  assign lb1_rd   = lb1_q[col_q];
  assign new_col  = {pix.data, lb1_rd, lb0_rd};
  assign last_col = (col_q == COL_LAST);
  assign last_row = (row_q == ROW_LAST);

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    valid_d      = 1'b0;
    out_col_d    = out_col_q;
    out_row_d    = out_row_q;
    frame_done_d = 1'b0;

    if (pix.en) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 2; c++) begin
          win_d[DATA_W*(3*r+c) +: DATA_W] = win_q[DATA_W*(3*r+c+1) +: DATA_W];
        end
        win_d[DATA_W*(3*r+2) +: DATA_W] = new_col[DATA_W*r +: DATA_W];
      end

      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end

      frame_done_d = last_col && last_row;

      // The col>=2 gate also hides the two windows that straddle a line wrap.
      if ((state_q == RUN) && (col_q >= COL_W'(2))) begin
        valid_d   = 1'b1;
        out_col_d = col_q - COL_W'(1);
        out_row_d = row_q - ROW_W'(1);
      end

      case (state_q)
        FILL: if (last_col && (row_q == ROW_W'(1))) state_d = RUN;
        RUN:  if (last_col && last_row)             state_d = FILL;
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= FILL;
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      valid_q      <= 1'b0;
      out_col_q    <= '0;
      out_row_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      valid_q      <= valid_d;
      out_col_q    <= out_col_d;
      out_row_q    <= out_row_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line RAMs are deliberately not reset; FILL gating keeps stale rows hidden.
  always_ff @(posedge clk) begin
    if (pix.en) begin
      lb0_q[col_q] <= lb1_rd;
      lb1_q[col_q] <= pix.data;
    end
  end

  assign pix.window     = win_q;
  assign pix.out_valid  = valid_q;
  assign pix.out_col    = out_col_q;
  assign pix.out_row    = out_row_q;
  assign pix.frame_done = frame_done_q;
endmodule
